// File: rtl/simd_dispatch_arbiter_pkg.sv
// Shared types and constants for the SIMD dispatch arbiter.
// Holds the kernel descriptor, the per-core occupancy state and the pointer helper.
package simd_dispatch_arbiter_pkg;

    localparam int NUM_SIMD_CORES    = 4;
    localparam int LOG2_SIMD_CORES   = 2;
    localparam int LOG2_THREAD_COUNT = 3;
    localparam int WARP_ID_W         = 4;

    // All-ones warp ID marks "no warp released this cycle".
    localparam logic [WARP_ID_W-1:0] NO_WARP_ID = 4'b1111;

    typedef struct packed {
        logic [31:0]                  start_pc;
        logic [LOG2_THREAD_COUNT-1:0] thread_count;
        logic [WARP_ID_W-1:0]         warp_id;
    } kernel_t;

    typedef enum logic [1:0] {
        FREE      = 2'b00,
        BUSY      = 2'b01,
        DONE_PEND = 2'b10
    } core_state_t;

    // Advance a round-robin pointer past the granted index, wrapping at the last core.
    function automatic logic [LOG2_SIMD_CORES-1:0] ptr_inc(input logic [LOG2_SIMD_CORES-1:0] p);
        return (p == LOG2_SIMD_CORES'(NUM_SIMD_CORES - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/simd_dispatch_arbiter_if.sv
// Handshake and core-side bus of the SIMD dispatch arbiter.
// The arbiter uses the slave modport; the scheduler/core side uses master.
interface simd_dispatch_arbiter_if;
    import simd_dispatch_arbiter_pkg::*;

    logic                                       kernel_valid;
    kernel_t                                    kernel_in;
    logic                                       kernel_ready;
    logic [NUM_SIMD_CORES-1:0]                  core_launch;
    logic [31:0]                                core_start_pc;
    logic [LOG2_THREAD_COUNT-1:0]               core_thread_count;
    logic [WARP_ID_W-1:0]                       core_warp_id;
    logic [NUM_SIMD_CORES-1:0]                  core_done;
    logic [NUM_SIMD_CORES-1:0][WARP_ID_W-1:0]   core_done_warp_id;
    logic [WARP_ID_W-1:0]                       finished_warp_id;
    logic                                       proto_err;

    modport slave (
        input  kernel_valid, kernel_in, core_done, core_done_warp_id,
        output kernel_ready, core_launch, core_start_pc, core_thread_count,
               core_warp_id, finished_warp_id, proto_err
    );

    modport master (
        output kernel_valid, kernel_in, core_done, core_done_warp_id,
        input  kernel_ready, core_launch, core_start_pc, core_thread_count,
               core_warp_id, finished_warp_id, proto_err
    );

endinterface

// File: rtl/simd_dispatch_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    int k;

    // Scan N positions starting at the pointer and keep the first hit.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = W'(k);
            end
        end
    end

endmodule

// File: rtl/simd_dispatch_arbiter.sv
// SIMD dispatch arbiter: round-robin kernel dispatch onto free cores and
// serialised return of finished warp IDs, one per cycle.
// Optional build macro DISPATCH_STATS_EN adds launch/retire counters and a
// high-water mark of occupied cores.
module simd_dispatch_arbiter
    import simd_dispatch_arbiter_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    simd_dispatch_arbiter_if.slave      bus
`ifdef DISPATCH_STATS_EN
    ,
    output logic [15:0]                 launch_count,
    output logic [15:0]                 retire_count,
    output logic [LOG2_SIMD_CORES:0]    max_busy
`endif
);

    core_state_t                  core_state_q [NUM_SIMD_CORES];
    core_state_t                  core_state_d [NUM_SIMD_CORES];
    logic [WARP_ID_W-1:0]         core_warp_q  [NUM_SIMD_CORES];
    logic [WARP_ID_W-1:0]         core_warp_d  [NUM_SIMD_CORES];
    logic [LOG2_SIMD_CORES-1:0]   disp_ptr_q, disp_ptr_d;
    logic [LOG2_SIMD_CORES-1:0]   ret_ptr_q, ret_ptr_d;
    logic [NUM_SIMD_CORES-1:0]    launch_q, launch_d;
    logic [31:0]                  start_pc_q, start_pc_d;
    logic [LOG2_THREAD_COUNT-1:0] thread_count_q, thread_count_d;
    logic [WARP_ID_W-1:0]         warp_id_q, warp_id_d;
    logic [WARP_ID_W-1:0]         finished_q, finished_d;
    logic                         proto_err_q, proto_err_d;

    logic [NUM_SIMD_CORES-1:0]    free_vec, pend_vec;
    logic [NUM_SIMD_CORES-1:0]    disp_gnt, ret_gnt;
    logic [LOG2_SIMD_CORES-1:0]   disp_idx, ret_idx;
    logic                         disp_any, ret_any;
    logic                         accept, alloc;

    // Occupancy request vectors for the two pickers.
    always_comb begin
        free_vec = '0;
        pend_vec = '0;
        for (int c = 0; c < NUM_SIMD_CORES; c++) begin
            free_vec[c] = (core_state_q[c] == FREE);
            pend_vec[c] = (core_state_q[c] == DONE_PEND);
        end
    end

    rr_pick #(.N(NUM_SIMD_CORES), .W(LOG2_SIMD_CORES)) u_disp_pick (
        .req_i (free_vec),
        .ptr_i (disp_ptr_q),
        .gnt_o (disp_gnt),
        .idx_o (disp_idx),
        .any_o (disp_any)
    );

    rr_pick #(.N(NUM_SIMD_CORES), .W(LOG2_SIMD_CORES)) u_ret_pick (
        .req_i (pend_vec),
        .ptr_i (ret_ptr_q),
        .gnt_o (ret_gnt),
        .idx_o (ret_idx),
        .any_o (ret_any)
    );

    assign bus.kernel_ready = disp_any && !rst;
    assign accept           = bus.kernel_valid && bus.kernel_ready;
    // A zero-thread kernel is consumed without taking a core.
    assign alloc            = accept && (bus.kernel_in.thread_count != '0);

    // Next state: dispatch, completion and retirement each need a different
    // source state, so they never touch the same core in one cycle.
    always_comb begin
        core_state_d   = core_state_q;
        core_warp_d    = core_warp_q;
        disp_ptr_d     = disp_ptr_q;
        ret_ptr_d      = ret_ptr_q;
        launch_d       = '0;
        start_pc_d     = start_pc_q;
        thread_count_d = thread_count_q;
        warp_id_d      = warp_id_q;
        finished_d     = NO_WARP_ID;
        proto_err_d    = proto_err_q;

        if (accept && !alloc) begin
            proto_err_d = 1'b1;
        end

        if (alloc) begin
            launch_d       = disp_gnt;
            start_pc_d     = bus.kernel_in.start_pc;
            thread_count_d = bus.kernel_in.thread_count;
            warp_id_d      = bus.kernel_in.warp_id;
            disp_ptr_d     = ptr_inc(disp_idx);
        end

        if (ret_any) begin
            finished_d = core_warp_q[ret_idx];
            ret_ptr_d  = ptr_inc(ret_idx);
        end

        for (int c = 0; c < NUM_SIMD_CORES; c++) begin
            if (alloc && disp_gnt[c]) begin
                core_state_d[c] = BUSY;
                core_warp_d[c]  = bus.kernel_in.warp_id;
            end
            if (bus.core_done[c]) begin
                if (core_state_q[c] == BUSY) begin
                    core_state_d[c] = DONE_PEND;
                    core_warp_d[c]  = bus.core_done_warp_id[c];
                end else begin
                    proto_err_d = 1'b1;
                end
            end
            if (ret_any && ret_gnt[c]) begin
                core_state_d[c] = FREE;
            end
        end
    end

    // State and output registers; reset discards all in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_SIMD_CORES; c++) begin
                core_state_q[c] <= FREE;
                core_warp_q[c]  <= '0;
            end
            disp_ptr_q     <= '0;
            ret_ptr_q      <= '0;
            launch_q       <= '0;
            start_pc_q     <= '0;
            thread_count_q <= '0;
            warp_id_q      <= '0;
            finished_q     <= NO_WARP_ID;
            proto_err_q    <= 1'b0;
        end else begin
            core_state_q   <= core_state_d;
            core_warp_q    <= core_warp_d;
            disp_ptr_q     <= disp_ptr_d;
            ret_ptr_q      <= ret_ptr_d;
            launch_q       <= launch_d;
            start_pc_q     <= start_pc_d;
            thread_count_q <= thread_count_d;
            warp_id_q      <= warp_id_d;
            finished_q     <= finished_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign bus.core_launch       = launch_q;
    assign bus.core_start_pc     = start_pc_q;
    assign bus.core_thread_count = thread_count_q;
    assign bus.core_warp_id      = warp_id_q;
    assign bus.finished_warp_id  = finished_q;
    assign bus.proto_err         = proto_err_q;

`ifdef DISPATCH_STATS_EN
    logic [15:0]              launch_cnt_q, retire_cnt_q;
    logic [LOG2_SIMD_CORES:0] max_busy_q, busy_cnt;

    // Number of cores currently holding work (BUSY or DONE_PEND).
    always_comb begin
        busy_cnt = '0;
        for (int c = 0; c < NUM_SIMD_CORES; c++) begin
            if (core_state_q[c] != FREE) begin
                busy_cnt = busy_cnt + 1'b1;
            end
        end
    end

    // Saturating event counters and occupancy high-water mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            launch_cnt_q <= '0;
            retire_cnt_q <= '0;
            max_busy_q   <= '0;
        end else begin
            if ((|launch_q) && (launch_cnt_q != 16'hFFFF)) begin
                launch_cnt_q <= launch_cnt_q + 16'd1;
            end
            if (ret_any && (retire_cnt_q != 16'hFFFF)) begin
                retire_cnt_q <= retire_cnt_q + 16'd1;
            end
            if (busy_cnt > max_busy_q) begin
                max_busy_q <= busy_cnt;
            end
        end
    end

    assign launch_count = launch_cnt_q;
    assign retire_count = retire_cnt_q;
    assign max_busy     = max_busy_q;
`endif

endmodule

// File: tb/tb_simd_dispatch_arbiter.sv
// Bench for simd_dispatch_arbiter: directed vector table, a bounded refill
// sequence and randomized traffic against a behavioural occupancy model.
module tb_simd_dispatch_arbiter;
    import simd_dispatch_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    simd_dispatch_arbiter_if bus();

`ifdef DISPATCH_STATS_EN
    logic [15:0] launch_count, retire_count;
    logic [LOG2_SIMD_CORES:0] max_busy;
`endif

    simd_dispatch_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef DISPATCH_STATS_EN
        ,
        .launch_count (launch_count),
        .retire_count (retire_count),
        .max_busy     (max_busy)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic vld, input logic [31:0] pc,
                         input logic [2:0] tc, input logic [3:0] w,
                         input logic [3:0] d, input logic [15:0] dw);
        rst                      = r;
        bus.kernel_valid         = vld;
        bus.kernel_in.start_pc   = pc;
        bus.kernel_in.thread_count = tc;
        bus.kernel_in.warp_id    = w;
        bus.core_done            = d;
        bus.core_done_warp_id    = dw;
    endtask

    // ---------------- behavioural model ----------------
    // Core occupancy: 0 = idle, 1 = running, 2 = finished awaiting release.
    int          ms [4];
    logic [3:0]  mw [4];
    int          mdp, mrp;
    logic [3:0]  e_launch;
    logic [31:0] e_pc;
    logic [2:0]  e_tc;
    logic [3:0]  e_wid, e_fin;
    logic        e_err;

    task automatic model_edge();
        int pre [4];
        logic [3:0] prew [4];
        int d, r, c;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin ms[i] = 0; mw[i] = 4'h0; end
            mdp = 0; mrp = 0;
            e_launch = 4'h0; e_pc = 0; e_tc = 0; e_wid = 0; e_fin = 4'hF; e_err = 1'b0;
            return;
        end
        pre = ms;
        prew = mw;
        d = -1; r = -1;
        for (int i = 0; i < 4; i++) begin
            c = (mdp + i) % 4;
            if (d < 0 && pre[c] == 0) d = c;
            c = (mrp + i) % 4;
            if (r < 0 && pre[c] == 2) r = c;
        end
        e_launch = 4'h0;
        e_fin    = 4'hF;
        if (bus.kernel_valid && d >= 0) begin
            if (bus.kernel_in.thread_count == 0) begin
                e_err = 1'b1;
            end else begin
                ms[d] = 1;
                mw[d] = bus.kernel_in.warp_id;
                e_launch = 4'(1 << d);
                e_pc  = bus.kernel_in.start_pc;
                e_tc  = bus.kernel_in.thread_count;
                e_wid = bus.kernel_in.warp_id;
                mdp   = (d + 1) % 4;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.core_done[i]) begin
                if (pre[i] == 1) begin
                    ms[i] = 2;
                    mw[i] = bus.core_done_warp_id[i];
                end else begin
                    e_err = 1'b1;
                end
            end
        end
        if (r >= 0) begin
            e_fin = prew[r];
            ms[r] = 0;
            mrp   = (r + 1) % 4;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic e_rdy;
        e_rdy = 1'b0;
        for (int i = 0; i < 4; i++) if (ms[i] == 0) e_rdy = 1'b1;
        e_rdy = e_rdy && !rst;
        chk({tag, ".launch"}, bus.core_launch, e_launch);
        chk({tag, ".pc"}, bus.core_start_pc, e_pc);
        chk({tag, ".tc"}, bus.core_thread_count, e_tc);
        chk({tag, ".wid"}, bus.core_warp_id, e_wid);
        chk({tag, ".fin"}, bus.finished_warp_id, e_fin);
        chk({tag, ".err"}, bus.proto_err, e_err);
        chk({tag, ".ready"}, bus.kernel_ready, e_rdy);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, valid;
        logic [31:0] pc;
        logic [2:0]  tc;
        logic [3:0]  wid, done;
        logic [15:0] dwid;
        logic [3:0]  el;
        logic [31:0] epc;
        logic [3:0]  ewid, efin;
        logic        erdy, eerr;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t v(logic r, logic vl, logic [31:0] pc, logic [2:0] tc,
                               logic [3:0] w, logic [3:0] d, logic [15:0] dw,
                               logic [3:0] el, logic [31:0] epc, logic [3:0] ew,
                               logic [3:0] ef, logic rd, logic er);
        vec_t x;
        x.rst = r; x.valid = vl; x.pc = pc; x.tc = tc; x.wid = w; x.done = d; x.dwid = dw;
        x.el = el; x.epc = epc; x.ewid = ew; x.efin = ef; x.erdy = rd; x.eerr = er;
        return x;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        drive(1, 0, 0, 0, 0, 0, 0);

        // rst | valid pc tc wid | done dwid || launch pc wid | fin ready err
        tbl.push_back(v(1,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'hF,0,0));
        tbl.push_back(v(0,1,'h100,3,0, 4'b0000,16'h0000, 4'b0001,'h100,0, 4'hF,1,0));
        tbl.push_back(v(0,1,'h200,3,1, 4'b0000,16'h0000, 4'b0010,'h200,1, 4'hF,1,0));
        tbl.push_back(v(0,1,'h300,3,2, 4'b0000,16'h0000, 4'b0100,'h300,2, 4'hF,1,0));
        tbl.push_back(v(0,1,'h400,3,3, 4'b0000,16'h0000, 4'b1000,'h400,3, 4'hF,0,0));
        tbl.push_back(v(0,1,'h500,3,4, 4'b0000,16'h0000, 4'b0000,0,0, 4'hF,0,0));
        tbl.push_back(v(0,1,'h500,3,4, 4'b0100,16'h0200, 4'b0000,0,0, 4'hF,0,0));
        tbl.push_back(v(0,1,'h500,3,4, 4'b0000,16'h0000, 4'b0000,0,0, 4'h2,1,0));
        tbl.push_back(v(0,1,'h500,3,4, 4'b0000,16'h0000, 4'b0100,'h500,4, 4'hF,0,0));
        // fresh fill, then all four complete together
        tbl.push_back(v(1,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'hF,0,0));
        tbl.push_back(v(0,1,'h10,3,0, 4'b0000,16'h0000, 4'b0001,'h10,0, 4'hF,1,0));
        tbl.push_back(v(0,1,'h20,3,1, 4'b0000,16'h0000, 4'b0010,'h20,1, 4'hF,1,0));
        tbl.push_back(v(0,1,'h30,3,2, 4'b0000,16'h0000, 4'b0100,'h30,2, 4'hF,1,0));
        tbl.push_back(v(0,1,'h40,3,3, 4'b0000,16'h0000, 4'b1000,'h40,3, 4'hF,0,0));
        tbl.push_back(v(0,0,0,0,0, 4'b1111,16'h3210, 4'b0000,0,0, 4'hF,0,0));
        tbl.push_back(v(0,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'h0,1,0));
        tbl.push_back(v(0,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'h1,1,0));
        tbl.push_back(v(0,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'h2,1,0));
        tbl.push_back(v(0,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'h3,1,0));
        tbl.push_back(v(0,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'hF,1,0));
        // same-cycle accept (core 1), retire (core 0) and completion (core 3)
        tbl.push_back(v(0,1,'h50,3,5, 4'b0000,16'h0000, 4'b0001,'h50,5, 4'hF,1,0));
        tbl.push_back(v(0,1,'h60,3,6, 4'b0000,16'h0000, 4'b0010,'h60,6, 4'hF,1,0));
        tbl.push_back(v(0,1,'h70,3,7, 4'b0000,16'h0000, 4'b0100,'h70,7, 4'hF,1,0));
        tbl.push_back(v(0,1,'h80,3,8, 4'b0000,16'h0000, 4'b1000,'h80,8, 4'hF,0,0));
        tbl.push_back(v(0,0,0,0,0, 4'b0010,16'h0060, 4'b0000,0,0, 4'hF,0,0));
        tbl.push_back(v(0,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'h6,1,0));
        tbl.push_back(v(0,0,0,0,0, 4'b0001,16'h0005, 4'b0000,0,0, 4'hF,1,0));
        tbl.push_back(v(0,1,'h90,3,9, 4'b1000,16'h8000, 4'b0010,'h90,9, 4'h5,1,0));
        tbl.push_back(v(0,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'h8,1,0));
        // completion on an idle core is a protocol error, sticky
        tbl.push_back(v(0,0,0,0,0, 4'b0001,16'h000A, 4'b0000,0,0, 4'hF,1,1));
        tbl.push_back(v(0,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'hF,1,1));
        // zero-thread kernel: consumed, no launch, pointer untouched
        tbl.push_back(v(1,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'hF,0,0));
        tbl.push_back(v(0,1,'hB0,0,'hB, 4'b0000,16'h0000, 4'b0000,0,0, 4'hF,1,1));
        tbl.push_back(v(0,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'hF,1,1));
        tbl.push_back(v(0,1,'hC0,3,'hC, 4'b0000,16'h0000, 4'b0001,'hC0,'hC, 4'hF,1,1));
        tbl.push_back(v(0,1,'hD0,3,'hD, 4'b0000,16'h0000, 4'b0010,'hD0,'hD, 4'hF,1,1));
        // reset with work in flight discards it
        tbl.push_back(v(0,0,0,0,0, 4'b0001,16'h000C, 4'b0000,0,0, 4'hF,1,1));
        tbl.push_back(v(1,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'hF,0,0));
        tbl.push_back(v(0,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'hF,1,0));
        tbl.push_back(v(0,0,0,0,0, 4'b0000,16'h0000, 4'b0000,0,0, 4'hF,1,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].valid, tbl[i].pc, tbl[i].tc, tbl[i].wid,
                  tbl[i].done, tbl[i].dwid);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d.launch", i), bus.core_launch, tbl[i].el);
            if (tbl[i].el != 0 || tbl[i].rst) begin
                chk($sformatf("row%0d.pc", i), bus.core_start_pc, tbl[i].epc);
                chk($sformatf("row%0d.tc", i), bus.core_thread_count, tbl[i].rst ? 0 : 3);
                chk($sformatf("row%0d.wid", i), bus.core_warp_id, tbl[i].ewid);
            end
            chk($sformatf("row%0d.fin", i), bus.finished_warp_id, tbl[i].efin);
            chk($sformatf("row%0d.ready", i), bus.kernel_ready, tbl[i].erdy);
            chk($sformatf("row%0d.err", i), bus.proto_err, tbl[i].eerr);
`ifdef DISPATCH_STATS_EN
            if (tbl[i].rst) begin
                chk($sformatf("row%0d.launch_count", i), launch_count, 0);
                chk($sformatf("row%0d.retire_count", i), retire_count, 0);
                chk($sformatf("row%0d.max_busy", i), max_busy, 0);
            end
`endif
        end

        // Hand sequence: fill all cores, hold a kernel, free one, wait bounded for the refill.
        drive(1, 0, 0, 0, 0, 0, 0);
        step(); check_model("seq_rst");
        drive(0, 1, 'h1000, 2, 5, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bus.kernel_in.start_pc = 32'h1000 + 32'(i);
            step(); check_model("seq_fill");
        end
        bus.kernel_in.start_pc = 32'h2000;
        bus.core_done = 4'b0010;
        bus.core_done_warp_id = 16'h0070;
        step(); check_model("seq_done");
        bus.core_done = 4'b0000;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            step(); check_model("seq_wait");
            if (bus.core_launch != 4'b0000) seen = 1'b1;
        end
        chk("seq_refill_seen", seen, 1);

        // Randomized traffic against the model.
        drive(1, 0, 0, 0, 0, 0, 0);
        step(); check_model("rnd_rst");
        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  d;
            logic [15:0] dw;
            for (int c = 0; c < 4; c++) begin
                if (ms[c] == 1) d[c] = ($urandom_range(0, 3) == 0);
                else            d[c] = ($urandom_range(0, 199) == 0);
                dw[c*4 +: 4] = 4'($urandom_range(0, 14));
            end
            drive(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), $urandom,
                  ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
                  4'($urandom_range(0, 14)), d, dw);
            step(); check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
